// File: rtl/csr_file_pkg.sv
// Shared CSR definitions for the machine-mode register file: addresses,
// Zicsr operation encodings, constant values and address classification helpers.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
  // Only MIE (bit 3) and MPIE (bit 7) are backed by storage.
  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic csr_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access port shared by the trap controller (while trap_done is low)
// and the execute stage's Zicsr path (while trap_done is high).
interface csr_file_if;
  logic        trap_done;
  logic        csr_trap_write_enable;
  logic [11:0] csr_trap_address;
  logic [31:0] csr_trap_write_data;
  logic [11:0] csr_address;
  logic [1:0]  csr_op;
  logic [31:0] csr_operand;
  logic [31:0] csr_read_data;
  logic        csr_illegal;

  modport master (
    output trap_done, csr_trap_write_enable, csr_trap_address, csr_trap_write_data,
    output csr_address, csr_op, csr_operand,
    input  csr_read_data, csr_illegal
  );

  modport slave (
    input  trap_done, csr_trap_write_enable, csr_trap_address, csr_trap_write_data,
    input  csr_address, csr_op, csr_operand,
    output csr_read_data, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with separately writable halves; a write to one half
// overrides the increment for the bits it owns.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (wr_lo) begin
      lo_d = wr_data;
    end else if (wr_hi) begin
      // Low half keeps counting, but its carry must not disturb the written high half.
      hi_d = wr_data;
      lo_d = lo_q + {31'b0, inc_en};
    end else if (inc_en) begin
      {hi_d, lo_d} = {hi_q, lo_q} + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read of the port owning the address,
// clocked commit with the trap port taking priority over Zicsr instructions.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  csr_file_if.slave    bus,
  input  logic         instret,
  output logic [31:0]  mtvec_out,
  output logic [31:0]  mepc_out
);

  localparam logic [31:0] MTVEC_INIT = MTVEC_RESET & ~32'h3;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle, minstret;

  csr_op_e     op;
  logic [11:0] eff_addr;
  logic [31:0] old_val;
  logic [31:0] wr_data;
  logic        instr_active, illegal, trap_wr, wr_en;
  logic        mcycle_wr_lo, mcycle_wr_hi, minstret_wr_lo, minstret_wr_hi;

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    op       = csr_op_e'(bus.csr_op);
    eff_addr = bus.trap_done ? bus.csr_address : bus.csr_trap_address;
    old_val  = '0;
    case (eff_addr)
      CSR_MSTATUS:   old_val = mstatus_q;
      CSR_MISA:      old_val = MISA_VALUE;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      CSR_MHARTID:   old_val = HART_ID;
      default:       old_val = '0;
    endcase
  end

  always_comb begin
    instr_active = bus.trap_done && (op != CSR_OP_NONE);
    illegal      = instr_active &&
                   (!csr_implemented(bus.csr_address) ||
                    (csr_read_only(bus.csr_address) &&
                     (op == CSR_OP_WRITE || bus.csr_operand != 32'h0)));
    trap_wr      = !bus.trap_done && bus.csr_trap_write_enable;
    wr_en        = trap_wr || (instr_active && !illegal);

    if (trap_wr) begin
      wr_data = bus.csr_trap_write_data;
    end else begin
      case (op)
        CSR_OP_WRITE: wr_data = bus.csr_operand;
        CSR_OP_SET:   wr_data = old_val | bus.csr_operand;
        CSR_OP_CLEAR: wr_data = old_val & ~bus.csr_operand;
        default:      wr_data = old_val;
      endcase
    end
  end

  assign bus.csr_read_data = old_val;
  assign bus.csr_illegal   = illegal;

  always_comb begin
    mstatus_d      = mstatus_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_wr_lo   = 1'b0;
    mcycle_wr_hi   = 1'b0;
    minstret_wr_lo = 1'b0;
    minstret_wr_hi = 1'b0;
    // Read-only and unimplemented addresses simply have no write target here.
    if (wr_en) begin
      case (eff_addr)
        CSR_MSTATUS:   mstatus_d      = wr_data & MSTATUS_MASK;
        CSR_MTVEC:     mtvec_d        = {wr_data[31:2], 2'b00};
        CSR_MSCRATCH:  mscratch_d     = wr_data;
        CSR_MEPC:      mepc_d         = {wr_data[31:2], 2'b00};
        CSR_MCAUSE:    mcause_d       = wr_data;
        CSR_MCYCLE:    mcycle_wr_lo   = 1'b1;
        CSR_MCYCLEH:   mcycle_wr_hi   = 1'b1;
        CSR_MINSTRET:  minstret_wr_lo = 1'b1;
        CSR_MINSTRETH: minstret_wr_hi = 1'b1;
        default:       ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments; the asynchronous reset clears them without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_q  <= '0;
      mtvec_q    <= MTVEC_INIT;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (1'b1),
    .wr_lo   (mcycle_wr_lo),
    .wr_hi   (mcycle_wr_hi),
    .wr_data (wr_data),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (instret),
    .wr_lo   (minstret_wr_lo),
    .wr_hi   (minstret_wr_hi),
    .wr_data (wr_data),
    .count   (minstret)
  );

  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;

endmodule
